// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe controller: cell marks, winner codes,
// FSM states, keypad bit positions and the eight winning-line cell masks.
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'd0;
   localparam logic [1:0] CELL_X     = 2'd1;
   localparam logic [1:0] CELL_O     = 2'd2;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_X    = 2'd1;
   localparam logic [1:0] WIN_O    = 2'd2;
   localparam logic [1:0] WIN_DRAW = 2'd3;

   typedef enum logic [1:0] {
      ST_MAIN  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_CHECK = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic [3:0] KEY_1    = 4'd0;
   localparam logic [3:0] KEY_2    = 4'd1;
   localparam logic [3:0] KEY_3    = 4'd2;
   localparam logic [3:0] KEY_4    = 4'd3;
   localparam logic [3:0] KEY_5    = 4'd4;
   localparam logic [3:0] KEY_6    = 4'd5;
   localparam logic [3:0] KEY_7    = 4'd6;
   localparam logic [3:0] KEY_8    = 4'd7;
   localparam logic [3:0] KEY_9    = 4'd8;
   localparam logic [3:0] KEY_STAR = 4'd9;
   localparam logic [3:0] KEY_0    = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   localparam logic [8:0] LINE_R0 = 9'b000_000_111;
   localparam logic [8:0] LINE_R1 = 9'b000_111_000;
   localparam logic [8:0] LINE_R2 = 9'b111_000_000;
   localparam logic [8:0] LINE_C0 = 9'b001_001_001;
   localparam logic [8:0] LINE_C1 = 9'b010_010_010;
   localparam logic [8:0] LINE_C2 = 9'b100_100_100;
   localparam logic [8:0] LINE_D0 = 9'b100_010_001;
   localparam logic [8:0] LINE_D1 = 9'b001_010_100;

   // Index 0 is LINE_R0; lower index has priority when several lines match.
   localparam logic [7:0][8:0] WIN_LINES =
      {LINE_D1, LINE_D0, LINE_C2, LINE_C1, LINE_C0, LINE_R2, LINE_R1, LINE_R0};

   function automatic logic [8:0] find_win(input logic [17:0] brd, input logic [1:0] mark);
      logic [8:0] line;
      logic       hit;
      line = '0;
      for (int l = 7; l >= 0; l--) begin
         hit = 1'b1;
         for (int c = 0; c < 9; c++)
            if (WIN_LINES[l][c] && (brd[2*c +: 2] != mark)) hit = 1'b0;
         if (hit) line = WIN_LINES[l];
      end
      return line;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Turns the raw one-hot keypad word into single accept pulses: a key must be
// stable for DEBOUNCE_CYCLES, and a full release must be seen before the next.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] key_data,
   output logic        key_acc,
   output logic [3:0]  key_idx
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [11:0]   r_key;
   logic [CW-1:0] r_cnt;
   logic          r_armed;
   logic          w_onehot;
   logic [3:0]    w_idx;

   assign w_onehot = $onehot(r_key);

   always_comb begin
      w_idx = '0;
      for (int b = 0; b < 12; b++)
         if (r_key[b]) w_idx = 4'(b);
   end

   // Reset leaves the block disarmed so a key held through reset must be
   // released and pressed again before it is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key   <= '0;
         r_cnt   <= '0;
         r_armed <= 1'b0;
         key_acc <= 1'b0;
         key_idx <= '0;
      end else begin
         r_key   <= key_data;
         key_acc <= 1'b0;
         if (key_data != r_key)
            r_cnt <= '0;
         else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
         if (r_cnt == CNT_MAX) begin
            if (w_onehot && r_armed) begin
               key_acc <= 1'b1;
               key_idx <= w_idx;
               r_armed <= 1'b0;
            end else if (!w_onehot) begin
               r_armed <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: debounced keypad in, MAIN/PLAY/CHECK/OVER FSM,
// 3x3 board, turn tracking and win/draw detection, all outputs registered.
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] key_data,
   output logic [17:0] board,
   output logic        turn_o,
   output logic        in_main,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic [8:0]  win_line,
   output logic        move_valid,
   output logic        move_reject
);

   logic       w_key_acc;
   logic [3:0] w_key_idx;
   state_t     r_state;
   logic [3:0] r_moves;
   logic       w_is_cell;
   logic [1:0] w_cell;
   logic [1:0] w_mark;
   logic [1:0] w_moved;
   logic [8:0] w_line;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .key_data (key_data),
      .key_acc  (w_key_acc),
      .key_idx  (w_key_idx)
   );

   // In CHECK the turn has already toggled, so the mover is the opposite mark.
   always_comb begin
      w_is_cell = (w_key_idx <= KEY_9);
      w_cell    = CELL_EMPTY;
      for (int c = 0; c < 9; c++)
         if (w_key_idx == 4'(c)) w_cell = board[2*c +: 2];
      w_mark  = turn_o ? CELL_O : CELL_X;
      w_moved = turn_o ? CELL_X : CELL_O;
      w_line  = find_win(board, w_moved);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_MAIN;
         r_moves     <= '0;
         board       <= '0;
         turn_o      <= 1'b0;
         in_main     <= 1'b1;
         game_over   <= 1'b0;
         winner      <= WIN_NONE;
         win_line    <= '0;
         move_valid  <= 1'b0;
         move_reject <= 1'b0;
      end else begin
         move_valid  <= 1'b0;
         move_reject <= 1'b0;
         case (r_state)
            ST_MAIN: begin
               if (w_key_acc && (w_key_idx == KEY_1)) begin
                  board   <= '0;
                  turn_o  <= 1'b0;
                  r_moves <= '0;
                  in_main <= 1'b0;
                  r_state <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (w_key_acc) begin
                  if (w_is_cell) begin
                     if (w_cell == CELL_EMPTY) begin
                        for (int c = 0; c < 9; c++)
                           if (w_key_idx == 4'(c)) board[2*c +: 2] <= w_mark;
                        turn_o     <= ~turn_o;
                        if (r_moves != 4'd9) r_moves <= r_moves + 4'd1;
                        move_valid <= 1'b1;
                        r_state    <= ST_CHECK;
                     end else begin
                        move_reject <= 1'b1;
                     end
                  end else if (w_key_idx == KEY_HASH) begin
                     in_main <= 1'b1;
                     r_state <= ST_MAIN;
                  end
               end
            end
            ST_CHECK: begin
               if (w_line != '0) begin
                  winner    <= w_moved;
                  win_line  <= w_line;
                  game_over <= 1'b1;
                  r_state   <= ST_OVER;
               end else if (r_moves == 4'd9) begin
                  winner    <= WIN_DRAW;
                  win_line  <= '0;
                  game_over <= 1'b1;
                  r_state   <= ST_OVER;
               end else begin
                  r_state <= ST_PLAY;
               end
            end
            ST_OVER: begin
               if (w_key_acc) begin
                  winner    <= WIN_NONE;
                  win_line  <= '0;
                  game_over <= 1'b0;
                  in_main   <= 1'b1;
                  r_state   <= ST_MAIN;
               end
            end
            default: r_state <= ST_MAIN;
         endcase
      end
   end

endmodule
